// File: rtl/mux_fault_pipe.sv
// Registered N-way mux with valid/ready handshake and single-bit fault engine.
// Ports: clk_i/rst_n_i; data_i/select_i/valid_i/ready_o in; data_o/valid_o/ready_i out;
//        fault_arm_i/clr_i/bit_i/type_i/delay_i/len_i control; fault_active_o/cnt_o status.
// Build option: define MUX_FAULT_INJ_EN to compile in the fault campaign engine.
module mux_fault_pipe #(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 2,
    localparam int SEL_W  = $clog2(NUM_IN),
    localparam int BIT_W  = $clog2(WIDTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [NUM_IN*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]        select_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [WIDTH-1:0]        data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    input  logic                    fault_arm_i,
    input  logic                    fault_clr_i,
    input  logic [BIT_W-1:0]        fault_bit_i,
    input  logic [1:0]              fault_type_i,
    input  logic [7:0]              fault_delay_i,
    input  logic [7:0]              fault_len_i,
    output logic                    fault_active_o,
    output logic [15:0]             fault_cnt_o
);

    logic             w_acc;
    logic [WIDTH-1:0] w_clean;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    assign ready_o = !r_valid || ready_i;
    assign w_acc   = valid_i && ready_o;
    assign data_o  = r_data;
    assign valid_o = r_valid;

    // Out-of-range selects match no channel and yield zero.
    always_comb begin
        w_clean = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (select_i == SEL_W'(k))
                w_clean = data_i[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_acc) begin
            r_data  <= w_load;
            r_valid <= 1'b1;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

`ifdef MUX_FAULT_INJ_EN

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [BIT_W-1:0] r_bit;
    logic [1:0]       r_type;
    logic [7:0]       r_dly;
    logic [7:0]       r_len;
    logic [15:0]      r_cnt;
    logic             r_active;
    logic             w_fault_on;
    logic             w_arm_ok;
    logic [WIDTH-1:0] w_mask;

    assign w_arm_ok = fault_arm_i && (fault_type_i != 2'b00);

    // State register plus latched campaign fields and counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= S_IDLE;
            r_active <= 1'b0;
            r_bit    <= '0;
            r_type   <= '0;
            r_dly    <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_next;
            r_active <= (w_next == S_ACTIVE);
            if (!fault_clr_i) begin
                case (r_state)
                    S_IDLE: if (w_arm_ok) begin
                        r_bit  <= fault_bit_i;
                        r_type <= fault_type_i;
                        r_dly  <= fault_delay_i;
                        r_len  <= fault_len_i;
                    end
                    S_DELAY: if (w_acc) r_dly <= r_dly - 8'd1;
                    S_ACTIVE: if (w_acc && r_len != 8'd0) r_len <= r_len - 8'd1;
                    default: ;
                endcase
            end
            // Masked faults (value unchanged) are not counted.
            if (w_fault_on && w_acc && (w_load != w_clean) && (r_cnt != 16'hFFFF))
                r_cnt <= r_cnt + 16'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_arm_ok)
                w_next = (fault_delay_i == 8'd0) ? S_ACTIVE : S_DELAY;
            S_DELAY: if (w_acc && r_dly == 8'd1)
                w_next = S_ACTIVE;
            S_ACTIVE: if (w_acc && r_len == 8'd1)
                w_next = S_DONE;
            S_DONE:
                w_next = S_IDLE;
            default:
                w_next = S_IDLE;
        endcase
        if (fault_clr_i)
            w_next = S_IDLE;
    end

    // Bit indices at or beyond WIDTH produce an empty mask.
    always_comb begin
        w_fault_on = (r_state == S_ACTIVE);
        w_mask     = '0;
        for (int b = 0; b < WIDTH; b++)
            w_mask[b] = (r_bit == BIT_W'(b));
        w_load = w_clean;
        if (w_fault_on) begin
            case (r_type)
                2'b01:   w_load = w_clean & ~w_mask;
                2'b10:   w_load = w_clean | w_mask;
                2'b11:   w_load = w_clean ^ w_mask;
                default: w_load = w_clean;
            endcase
        end
    end

    assign fault_active_o = r_active;
    assign fault_cnt_o    = r_cnt;

`else

    logic w_unused;

    assign w_unused = ^{fault_arm_i, fault_clr_i, fault_bit_i,
                        fault_type_i, fault_delay_i, fault_len_i};
    assign w_load         = w_clean;
    assign fault_active_o = 1'b0;
    assign fault_cnt_o    = 16'd0;

`endif

endmodule

// File: tb/tb_mux_fault_pipe.sv
// Directed self-checking bench for mux_fault_pipe (NUM_IN=4 and NUM_IN=3 instances).
// Expected values follow the build: faulted values only when MUX_FAULT_INJ_EN is defined.
module tb_mux_fault_pipe;

`ifdef MUX_FAULT_INJ_EN
    localparam bit FI = 1'b1;
`else
    localparam bit FI = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [127:0]  data;
    logic [1:0]    sel;
    logic          valid;
    logic          ready_o;
    logic [31:0]   data_o;
    logic          valid_o;
    logic          ready_i;
    logic          arm;
    logic          clr;
    logic [4:0]    fbit;
    logic [1:0]    ftype;
    logic [7:0]    fdly;
    logic [7:0]    flen;
    logic          active;
    logic [15:0]   cnt;

    logic [95:0]   d1;
    logic [1:0]    sel1;
    logic          v1;
    logic          rdy1_o;
    logic [31:0]   dout1;
    logic          vout1;
    logic          act1;
    logic [15:0]   cnt1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_fault_pipe #(.WIDTH(32), .NUM_IN(4)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .select_i(sel),
        .valid_i(valid), .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .fault_arm_i(arm), .fault_clr_i(clr),
        .fault_bit_i(fbit), .fault_type_i(ftype), .fault_delay_i(fdly),
        .fault_len_i(flen), .fault_active_o(active), .fault_cnt_o(cnt)
    );

    mux_fault_pipe #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(d1), .select_i(sel1),
        .valid_i(v1), .ready_o(rdy1_o), .data_o(dout1), .valid_o(vout1),
        .ready_i(1'b1), .fault_arm_i(1'b0), .fault_clr_i(1'b0),
        .fault_bit_i(5'd0), .fault_type_i(2'b00), .fault_delay_i(8'd0),
        .fault_len_i(8'd0), .fault_active_o(act1), .fault_cnt_o(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ch [4];
    logic [31:0] flip_d [6];
    logic        flip_a [6];
    logic [15:0] flip_c [6];

    initial begin
        ch[0] = 32'h11111111; ch[1] = 32'h22222222;
        ch[2] = 32'h33333333; ch[3] = 32'h44444444;
        flip_d[0] = 32'h0; flip_d[1] = 32'h0; flip_d[2] = 32'h20;
        flip_d[3] = 32'h20; flip_d[4] = 32'h20; flip_d[5] = 32'h0;
        flip_a[0] = 0; flip_a[1] = 1; flip_a[2] = 1;
        flip_a[3] = 1; flip_a[4] = 0; flip_a[5] = 0;
        flip_c[0] = 0; flip_c[1] = 0; flip_c[2] = 1;
        flip_c[3] = 2; flip_c[4] = 3; flip_c[5] = 3;

        rst_n = 1'b0; data = {ch[3], ch[2], ch[1], ch[0]}; sel = '0;
        valid = 0; ready_i = 1; arm = 0; clr = 0; fbit = 0; ftype = 0;
        fdly = 0; flen = 0;
        d1 = {ch[2], ch[1], ch[0]}; sel1 = 0; v1 = 0;

        #12;
        check("rst_data", data_o, 32'h0);
        check("rst_valid", valid_o, 32'h0);
        check("rst_ready", ready_o, 32'h1);
        check("rst_active", active, 32'h0);
        check("rst_cnt", cnt, 32'h0);
        step();
        rst_n = 1'b1;

        // Clean mux across all four channels
        for (int s = 0; s < 4; s++) begin
            valid = 1; sel = 2'(s);
            step();
            check("mux_data", data_o, ch[s]);
            check("mux_valid", valid_o, 32'h1);
        end
        valid = 0;
        step();
        check("mux_drain", valid_o, 32'h0);

        // Out-of-range select on the 3-input instance
        v1 = 1; sel1 = 2'd3;
        step();
        check("oor_data", dout1, 32'h0);
        check("oor_valid", vout1, 32'h1);
        sel1 = 2'd2;
        step();
        check("n3_ch2", dout1, ch[2]);
        v1 = 0;

        // Backpressure: first accept lands, then 5 stalled cycles
        ready_i = 0; valid = 1; sel = 2'd1;
        step();
        check("bp_first", data_o, ch[1]);
        sel = 2'd2;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_ready", ready_o, 32'h0);
            check("bp_hold", data_o, ch[1]);
            check("bp_valid", valid_o, 32'h1);
        end
        ready_i = 1;
        step();
        check("bp_release", data_o, ch[2]);
        valid = 0;
        step();
        check("bp_drain", valid_o, 32'h0);

        // Delayed flip: bit 5, delay 2, len 3 on a zero stream
        data = {ch[3], ch[2], ch[1], 32'h0}; sel = 0;
        arm = 1; ftype = 2'b11; fbit = 5'd5; fdly = 8'd2; flen = 8'd3;
        step();
        arm = 0;
        check("flip_armed_act", active, 32'h0);
        for (int i = 0; i < 6; i++) begin
            valid = 1;
            step();
            check("flip_data", data_o, FI ? flip_d[i] : 32'h0);
            check("flip_active", active, FI ? 32'(flip_a[i]) : 32'h0);
            check("flip_cnt", cnt, FI ? 32'(flip_c[i]) : 32'h0);
        end
        valid = 0;
        step();

        // Masked stuck-at-1 on bit 0, len 2
        arm = 1; ftype = 2'b10; fbit = 5'd0; fdly = 8'd0; flen = 8'd2;
        step();
        arm = 0;
        check("sa1_active", active, FI ? 32'h1 : 32'h0);
        data[31:0] = 32'h1; valid = 1;
        step();
        check("sa1_masked", data_o, 32'h1);
        check("sa1_cnt0", cnt, FI ? 32'd3 : 32'd0);
        data[31:0] = 32'h2;
        step();
        check("sa1_hit", data_o, FI ? 32'h3 : 32'h2);
        check("sa1_cnt1", cnt, FI ? 32'd4 : 32'd0);
        valid = 0;
        step();

        // Permanent stuck-at-0 on bit 31, rearm ignored, then abort
        arm = 1; ftype = 2'b01; fbit = 5'd31; fdly = 8'd0; flen = 8'd0;
        step();
        arm = 0;
        data[31:0] = 32'hFFFFFFFF; valid = 1;
        step();
        check("perm_1", data_o, FI ? 32'h7FFFFFFF : 32'hFFFFFFFF);
        arm = 1; ftype = 2'b11; fbit = 5'd0;
        step();
        arm = 0;
        check("perm_2", data_o, FI ? 32'h7FFFFFFF : 32'hFFFFFFFF);
        step();
        check("perm_3", data_o, FI ? 32'h7FFFFFFF : 32'hFFFFFFFF);
        check("perm_cnt", cnt, FI ? 32'd7 : 32'd0);
        valid = 0; clr = 1;
        step();
        clr = 0;
        check("clr_active", active, 32'h0);
        check("clr_hold", data_o, FI ? 32'h7FFFFFFF : 32'hFFFFFFFF);
        valid = 1;
        step();
        check("clr_clean", data_o, 32'hFFFFFFFF);
        valid = 0;
        step();

        // Async reset while in DELAY with output stalled
        arm = 1; ftype = 2'b11; fbit = 5'd0; fdly = 8'd5; flen = 8'd1;
        step();
        arm = 0;
        ready_i = 0; valid = 1;
        step();
        check("ar_pre_valid", valid_o, 32'h1);
        #2;
        rst_n = 0;
        #1;
        check("ar_data", data_o, 32'h0);
        check("ar_valid", valid_o, 32'h0);
        check("ar_ready", ready_o, 32'h1);
        check("ar_active", active, 32'h0);
        check("ar_cnt", cnt, 32'h0);
        valid = 0; ready_i = 1;
        step();
        rst_n = 1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_fault_pipe.md
# mux_fault_pipe

Parametrised, registered N-way multiplexer with a valid/ready handshake and a built-in single-bit fault-injection engine. It generalises the 32-bit 2:1 datapath mux from one width and two inputs to any width and input count, and replaces the unused fault pin with a sequenced stuck-at/bit-flip campaign. It sits on datapath select points of the fault-generation test CPU, where faults are armed by the campaign controller.

## Interface
- `WIDTH`, default 32: data width per channel.
- `NUM_IN`, default 2: number of input channels, at least 2. Derived `SEL_W = $clog2(NUM_IN)` and `BIT_W = $clog2(WIDTH)`.

- `clk_i`  in  1  clock; all state is rising-edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `data_i`  in  NUM_IN*WIDTH  channel k is at `[k*WIDTH +: WIDTH]`.
- `select_i`  in  SEL_W  channel select, sampled with `valid_i`.
- `valid_i`  in  1  input valid.
- `ready_o`  out  1  input ready.
- `data_o`  out  WIDTH  registered output.
- `valid_o`  out  1  output valid.
- `ready_i`  in  1  downstream ready.
- `fault_arm_i`  in  1  one-cycle strobe that arms a campaign.
- `fault_clr_i`  in  1  synchronous abort; takes priority over arm.
- `fault_bit_i`  in  BIT_W  target bit index.
- `fault_type_i`  in  2  fault type: 00 none, 01 stuck-at-0, 10 stuck-at-1, 11 flip.
- `fault_delay_i`  in  8  number of clean transfers before the fault starts.
- `fault_len_i`  in  8  number of faulted transfers; 0 means permanent.
- `fault_active_o`  out  1  high while the FSM is in ACTIVE.
- `fault_cnt_o`  out  16  count of transfers actually corrupted; saturating.

## Operation
- Accept: `acc = valid_i && ready_o`. `ready_o = !valid_o || ready_i` (combinational).
- On `acc`, the output register loads `clean = data_i[select_i]`, or all-zero if `select_i >= NUM_IN`.
  - In ACTIVE, the fault is applied to bit `fault_bit` of that value before the load.
  - An index `fault_bit >= WIDTH` corrupts nothing.
- Output hold:
  - `valid_o` sets on `acc`.
  - `valid_o` clears when `valid_o && ready_i && !acc`.
  - While stalled, `data_o` is held unchanged. State changes never alter the held data.
- FSM states: IDLE, DELAY, ACTIVE, DONE.
  - IDLE: on `fault_arm_i` with type ≠ 00, latch bit, type, delay and len.
    - If delay = 0, go to ACTIVE; otherwise go to DELAY.
    - Arm with type 00 is ignored.
  - DELAY: decrement the delay count on each `acc`. Going from 1 to 0 moves to ACTIVE, so transfer D+1 is the first faulted one.
  - ACTIVE: faults every accepted transfer.
    - If len ≠ 0, decrement on each `acc`; going from 1 to 0 moves to DONE.
    - If len = 0, stay in ACTIVE until `fault_clr_i`.
  - DONE: return to IDLE on the next cycle.
- `fault_arm_i` outside IDLE is ignored.
- `fault_clr_i` in any state goes to IDLE next cycle. It is not blocked by stalls, and it does not affect data already registered.
- `fault_cnt_o` increments on an ACTIVE `acc` only when the faulted value differs from `clean`. It saturates at 0xFFFF and clears only on reset.

## Timing
- Latency: an accepted input appears on `data_o`/`valid_o` 1 cycle later.
- Throughput is 1 per cycle when `ready_i` is held high.
- Reset values:
  - `data_o` = 0, `valid_o` = 0, `fault_active_o` = 0, `fault_cnt_o` = 0.
  - FSM in IDLE, all latched fault fields 0.
  - `ready_o` = 1.
- Arm sampled in cycle t takes effect from t+1. A transfer accepted in cycle t is clean, and is not counted toward delay.
- `fault_active_o` is registered and equals (state == ACTIVE).
- Reset asserted mid-campaign or mid-stall clears everything immediately. The in-flight output is dropped.

## Configuration
- `MUX_FAULT_INJ_EN` defined: FSM, fault latches and counter are compiled in, as described above.
- `MUX_FAULT_INJ_EN` not defined: all fault inputs are ignored and the datapath is always clean.
  - `fault_active_o` and `fault_cnt_o` are tied to 0.
  - Mux and handshake behaviour are identical in both builds.

## Test plan
- Clean mux:
  - Stimulus: WIDTH=32, NUM_IN=4, channels 0x11111111/0x22222222/0x33333333/0x44444444, `select_i` 0..3, `ready_i`=1.
  - Required: `data_o` matches the selected channel one cycle after each accept. `select_i` out of range never occurs with NUM_IN=4, so it is checked separately at NUM_IN=3 with sel=3, giving `data_o`=0.
- Backpressure:
  - Stimulus: hold `ready_i`=0 for 5 cycles with `valid_i`=1.
  - Required: `ready_o`=0 and `data_o` stable. On release, no transfer is lost or duplicated.
- Delayed flip:
  - Stimulus: arm with type=11, bit=5, delay=2, len=3; stream 0x00000000.
  - Required: outputs are 0, 0, 0x20, 0x20, 0x20, then 0. `fault_cnt_o`=3. `fault_active_o` is high for exactly the ACTIVE window.
- Masked stuck-at:
  - Stimulus: SA1 on bit 0, len=2, data 0x1 then 0x2.
  - Required: outputs 0x1 and 0x3; `fault_cnt_o` increments by 1 only.
- Permanent fault and abort:
  - Stimulus: SA0, bit 31, len=0, data 0xFFFFFFFF.
  - Required: `data_o`=0x7FFFFFFF indefinitely. After `fault_clr_i`, the next accept gives 0xFFFFFFFF. An arm during ACTIVE is ignored.
- Async reset mid-campaign:
  - Stimulus: pull `rst_n_i` low while in DELAY with `valid_o`=1.
  - Required: all outputs go to their reset values without waiting for a clock edge.
